// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample streamer:
// controller states and the packed-sample geometry of a flash word.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        WAIT_TICK,
        EMIT,
        DONE
    } state_e;

    localparam int SAMPLES_PER_WORD = 4;
    localparam int SAMPLE_W         = 8;
    localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);

    localparam logic signed [SAMPLE_W-1:0] SILENCE = 8'h00;

endpackage

// File: rtl/audio_sample_streamer_if.sv
// Avalon-MM read-only bus between the streamer (master) and the flash (slave).
interface audio_sample_streamer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic [DATA_W-1:0] flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

// File: rtl/sample_unpacker.sv
// Holds one fetched flash word and walks its four signed bytes, lowest byte first.
module sample_unpacker
    import audio_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       advance,
    input  logic [DATA_W-1:0]          word_in,
    output logic signed [SAMPLE_W-1:0] byte_out,
    output logic                       last_byte
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = word_in;
            idx_d  = '0;
        end else if (advance && !last_byte) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // The word itself is pure data and is only ever read after a fresh load.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign byte_out  = $signed(word_q[idx_q*SAMPLE_W +: SAMPLE_W]);
    assign last_byte = (idx_q == IDX_W'(SAMPLES_PER_WORD - 1));

endmodule

// File: rtl/audio_sample_streamer.sv
// Plays an inclusive range of flash words as a stream of signed 8-bit samples,
// one per audio tick, and strobes the volume meter when it is idle.
module audio_sample_streamer
    import audio_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W-1:0]          end_addr,
    input  logic                       sample_tick,
    audio_sample_streamer_if.master    flash,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       meter_start,
    input  logic                       meter_finish,
    output logic                       busy,
    output logic                       done,
    output logic                       underrun
);

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [ADDR_W-1:0]          end_q, end_d;
    logic                       flash_read_q, flash_read_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       meter_start_q, meter_start_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       underrun_q, underrun_d;
    logic                       tick_pending_q, tick_pending_d;

    logic                       load_word;
    logic                       advance_byte;
    logic signed [SAMPLE_W-1:0] cur_byte;
    logic                       last_byte;

    sample_unpacker #(.DATA_W(DATA_W)) u_unpack (
        .clk      (clk),
        .reset    (reset),
        .load     (load_word),
        .advance  (advance_byte),
        .word_in  (flash.flash_readdata),
        .byte_out (cur_byte),
        .last_byte(last_byte)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        end_d          = end_q;
        flash_read_d   = flash_read_q;
        sample_d       = sample_q;
        meter_start_d  = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        underrun_d     = underrun_q;
        tick_pending_d = tick_pending_q;
        load_word      = 1'b0;
        advance_byte   = 1'b0;

        // Only one tick can be banked; a second one is dropped so playback slows rather than skips.
        if (busy_q && (state_q inside {REQUEST, WAIT_DATA, EMIT}) && sample_tick) begin
            if (tick_pending_q) begin
                underrun_d = 1'b1;
            end else begin
                tick_pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (play) begin
                    underrun_d = 1'b0;
                    if (start_addr > end_addr) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d         = start_addr;
                        end_d          = end_addr;
                        busy_d         = 1'b1;
                        flash_read_d   = 1'b1;
                        tick_pending_d = 1'b0;
                        state_d        = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (!flash.flash_waitrequest) begin
                    flash_read_d = 1'b0;
                    state_d      = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash.flash_readdatavalid) begin
                    load_word = 1'b1;
                    state_d   = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick_pending_q || sample_tick) begin
                    tick_pending_d = tick_pending_q && sample_tick;
                    state_d        = EMIT;
                end
            end
            EMIT: begin
                sample_d      = cur_byte;
                meter_start_d = meter_finish;
                advance_byte  = 1'b1;
                // End compare precedes the increment, so an all-ones end address never wraps.
                if (!last_byte) begin
                    state_d = WAIT_TICK;
                end else if (addr_q == end_q) begin
                    state_d = DONE;
                end else begin
                    addr_d       = addr_q + 1'b1;
                    flash_read_d = 1'b1;
                    state_d      = REQUEST;
                end
            end
            DONE: begin
                done_d         = 1'b1;
                busy_d         = 1'b0;
                sample_d       = SILENCE;
                tick_pending_d = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            flash_read_q   <= 1'b0;
            sample_q       <= SILENCE;
            meter_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            tick_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            flash_read_q   <= flash_read_d;
            sample_q       <= sample_d;
            meter_start_q  <= meter_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            underrun_q     <= underrun_d;
            tick_pending_q <= tick_pending_d;
        end
        end_q <= end_d;
    end

    assign flash.flash_read    = flash_read_q;
    assign flash.flash_address = addr_q;
    assign sample              = sample_q;
    assign meter_start         = meter_start_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign underrun            = underrun_q;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer with a small Avalon flash model,
// a tick generator and a sample/meter monitor sharing one negedge process.
module tb_audio_sample_streamer;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              sample_tick;
    logic signed [7:0] sample;
    logic              meter_start;
    logic              meter_finish;
    logic              busy;
    logic              done;
    logic              underrun;

    audio_sample_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    audio_sample_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .sample_tick (sample_tick),
        .flash       (ifc),
        .sample      (sample),
        .meter_start (meter_start),
        .meter_finish(meter_finish),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Environment configuration and logs
    int              wait_cycles = 0;
    int              latency     = 1;
    int              tick_period = 0;
    int              tick_cnt    = 0;
    bit              meter_block = 1'b0;
    int              stall_cnt   = 0;
    int              lat_cnt     = 0;
    logic [22:0]     stall_addr  = '0;
    logic [22:0]     lat_addr    = '0;
    logic [22:0]     read_log[16];
    int              n_reads     = 0;
    logic [7:0]      samp_log[16];
    bit              mtr_log[16];
    int              n_samples   = 0;
    int              n_meter     = 0;
    logic [7:0]      prev_sample = 8'h00;

    logic [7:0] exp1[4] = '{8'hFE, 8'h02, 8'h7F, 8'h80};

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        logic [7:0] b;
        if (a == 23'h10) return 32'h807F02FE;
        b = {a[5:0], 2'b00} + 8'd1;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        ifc.flash_waitrequest   = 1'b0;
        ifc.flash_readdatavalid = 1'b0;
        ifc.flash_readdata      = '0;
        sample_tick             = 1'b0;
        meter_finish            = 1'b1;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && sample !== prev_sample) begin
                if (n_samples < 16) begin
                    samp_log[n_samples] = sample;
                    mtr_log[n_samples]  = meter_start;
                end
                n_samples++;
            end
            prev_sample = sample;
            if (meter_start === 1'b1) n_meter++;
            meter_finish = !(meter_block && (n_samples == 1 || n_samples == 2));

            sample_tick = 1'b0;
            if (tick_period > 0) begin
                tick_cnt++;
                if (tick_cnt >= tick_period) begin
                    sample_tick = 1'b1;
                    tick_cnt    = 0;
                end
            end

            ifc.flash_readdatavalid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    ifc.flash_readdatavalid = 1'b1;
                    ifc.flash_readdata      = mem_word(lat_addr);
                end
            end
            if (ifc.flash_read === 1'b1) begin
                if (stall_cnt == 0) stall_addr = ifc.flash_address;
                else check("stall_addr_hold", ifc.flash_address, stall_addr);
                if (stall_cnt < wait_cycles) begin
                    ifc.flash_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    ifc.flash_waitrequest = 1'b0;
                    stall_cnt = 0;
                    if (n_reads < 16) read_log[n_reads] = ifc.flash_address;
                    n_reads++;
                    lat_cnt  = latency;
                    lat_addr = ifc.flash_address;
                end
            end else begin
                ifc.flash_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    task automatic setup(input int wc, input int lat, input int tp, input bit mb);
        wait_cycles = wc;
        latency     = lat;
        tick_period = tp;
        tick_cnt    = 0;
        meter_block = mb;
        n_reads     = 0;
        n_samples   = 0;
        n_meter     = 0;
        @(negedge clk);
    endtask

    task automatic do_play(input logic [22:0] s, input logic [22:0] e);
        start_addr = s;
        end_addr   = e;
        play       = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; play = 1'b0; start_addr = '0; end_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_flash_read", ifc.flash_read, 0);
        check("rst_flash_addr", ifc.flash_address, 0);
        check("rst_sample", {24'h0, sample}, 0);
        check("rst_meter_start", meter_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single word, zero-wait slave
        setup(0, 1, 20, 1'b0);
        do_play(23'h10, 23'h10);
        check("t1_read_latency", ifc.flash_read, 1);
        check("t1_read_addr", ifc.flash_address, 23'h10);
        check("t1_busy", busy, 1);
        wait_done(400, "t1");
        check("t1_sample_silence", {24'h0, sample}, 0);
        check("t1_busy_low", busy, 0);
        check("t1_n_reads", n_reads, 1);
        check("t1_read0", read_log[0], 23'h10);
        check("t1_n_samples", n_samples, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_sample%0d", i), samp_log[i], exp1[i]);
        check("t1_n_meter", n_meter, 4);
        @(negedge clk);
        check("t1_done_one_cycle", done, 0);

        // Multi-word with stalls and read latency
        setup(3, 5, 50, 1'b0);
        do_play(23'h100, 23'h102);
        wait_done(1500, "t2");
        check("t2_n_reads", n_reads, 3);
        for (int i = 0; i < 3; i++) check($sformatf("t2_read%0d", i), read_log[i], 23'h100 + i);
        check("t2_n_samples", n_samples, 12);
        for (int i = 0; i < 12; i++) check($sformatf("t2_sample%0d", i), samp_log[i], i + 1);
        check("t2_n_meter", n_meter, 12);
        check("t2_underrun", underrun, 0);

        // Meter busy for the second and third samples
        setup(0, 1, 20, 1'b1);
        do_play(23'h10, 23'h10);
        wait_done(400, "t3");
        check("t3_n_samples", n_samples, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_sample%0d", i), samp_log[i], exp1[i]);
        check("t3_meter0", mtr_log[0], 1);
        check("t3_meter1", mtr_log[1], 0);
        check("t3_meter2", mtr_log[2], 0);
        check("t3_meter3", mtr_log[3], 1);
        check("t3_n_meter", n_meter, 2);

        // Underrun: fast ticks against a slow read
        setup(0, 10, 2, 1'b0);
        do_play(23'h10, 23'h10);
        wait_done(300, "t4");
        check("t4_underrun_at_done", underrun, 1);
        repeat (3) @(negedge clk);
        check("t4_underrun_sticky", underrun, 1);
        setup(0, 1, 20, 1'b0);
        do_play(23'h10, 23'h10);
        check("t4_underrun_cleared", underrun, 0);
        wait_done(400, "t4b");

        // Empty range: done next cycle, no read
        setup(0, 1, 20, 1'b0);
        do_play(23'h5, 23'h4);
        check("t5_done_next", done, 1);
        check("t5_no_read", ifc.flash_read, 0);
        check("t5_not_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("t5_n_reads", n_reads, 0);
        check("t5_done_pulse", done, 0);

        // Play while busy is ignored
        setup(0, 2, 10, 1'b0);
        do_play(23'h100, 23'h101);
        repeat (15) @(negedge clk);
        check("t5b_busy_before", busy, 1);
        do_play(23'h200, 23'h205);
        wait_done(500, "t5b");
        check("t5b_n_reads", n_reads, 2);
        check("t5b_read0", read_log[0], 23'h100);
        check("t5b_read1", read_log[1], 23'h101);
        check("t5b_n_samples", n_samples, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t5b_sample%0d", i), samp_log[i], i + 1);

        // Reset while waiting for the second word
        setup(0, 10, 10, 1'b0);
        do_play(23'h100, 23'h101);
        begin
            int k = 0;
            while (n_reads < 2 && k < 300) begin
                @(negedge clk);
                k++;
            end
        end
        check("t6_second_read", n_reads, 2);
        repeat (2) @(negedge clk);
        check("t6_pre_busy", busy, 1);
        check("t6_pre_sample", {24'h0, sample}, 8'h04);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_flash_read", ifc.flash_read, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_sample", {24'h0, sample}, 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_stray_busy", busy, 0);
        check("t6_stray_read", ifc.flash_read, 0);
        check("t6_stray_sample", {24'h0, sample}, 0);
        setup(0, 1, 20, 1'b0);
        do_play(23'h101, 23'h101);
        check("t6_new_addr", ifc.flash_address, 23'h101);
        wait_done(400, "t6");
        check("t6_n_reads", n_reads, 1);
        check("t6_read0", read_log[0], 23'h101);
        check("t6_n_samples", n_samples, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t6_sample%0d", i), samp_log[i], i + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
